// File: rtl/mult_wb_arbiter_pkg.sv
// Shared types and sizing for the multiply write-back arbiter.
// The grant enum names the four ways the register-file write port can be used each cycle.
package mult_wb_arbiter_pkg;

  localparam int REG_SIZE     = 32;
  localparam int REG_ADDR     = 5;
  localparam int MWB_DEPTH    = 8;
  localparam int MWB_MULT_LAT = 4;

  typedef struct packed {
    logic [REG_ADDR-1:0] wreg;
    logic [REG_SIZE-1:0] data;
    logic                zero;
    logic                ovf;
  } mwb_entry_t;

  localparam mwb_entry_t ENTRY_ZERO = '{wreg: {REG_ADDR{1'b0}}, data: {REG_SIZE{1'b0}},
                                        zero: 1'b0, ovf: 1'b0};

  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_MAIN   = 2'd1,
    GRANT_POP    = 2'd2,
    GRANT_BYPASS = 2'd3
  } grant_e;

endpackage

// File: rtl/mult_wb_fifo.sv
// In-order storage for multiply results waiting on the register-file write port.
// Exposes every slot's address/data/valid so the top can run a forwarding search.
module mult_wb_fifo
  import mult_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = MWB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  mwb_entry_t          push_entry,
  output mwb_entry_t          head_entry,
  output logic [PTR_W-1:0]    head_ptr,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty,
  output logic [REG_ADDR-1:0] entry_wreg [DEPTH],
  output logic [REG_SIZE-1:0] entry_data [DEPTH],
  output logic [DEPTH-1:0]    entry_valid
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  mwb_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] age_s [DEPTH];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push) tail_r <= tail_r + PTR_ONE;
      if (pop)  head_r <= head_r + PTR_ONE;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; slots outside the valid window are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_r[tail_r] <= push_entry;
  end

  // Slot is valid when its distance from head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_s[i]       = PTR_W'(i) - head_r;
      entry_valid[i] = ({1'b0, age_s[i]} < count_r);
      entry_wreg[i]  = mem_r[i].wreg;
      entry_data[i]  = mem_r[i].data;
    end
  end

  assign head_entry = mem_r[head_r];
  assign head_ptr   = head_r;
  assign count      = count_r;
  assign full       = (count_r == CNT_W'(DEPTH));
  assign empty      = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mult_wb_arbiter.sv
// Owns the single register-file write port: main pipe first, then queued multiply results,
// then a same-cycle bypass. Also forwards queued results and throttles multiply issue.
module mult_wb_arbiter
  import mult_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = MWB_DEPTH,
  parameter int MULT_LAT = MWB_MULT_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_regwrite_in,
  input  logic [REG_ADDR-1:0] m_wreg_in,
  input  logic [REG_SIZE-1:0] m_result_in,
  input  logic                m_zero_in,
  input  logic                m_overflow_in,
  input  logic                wb_regwrite,
  input  logic [REG_ADDR-1:0] wb_wreg,
  input  logic [REG_SIZE-1:0] wb_wdata,
  input  logic [REG_ADDR-1:0] rs_addr,
  input  logic [REG_ADDR-1:0] rt_addr,
  output logic                rf_we,
  output logic [REG_ADDR-1:0] rf_waddr,
  output logic [REG_SIZE-1:0] rf_wdata,
  output logic                fwd_rs_hit,
  output logic [REG_SIZE-1:0] fwd_rs_data,
  output logic                fwd_rt_hit,
  output logic [REG_SIZE-1:0] fwd_rt_data,
  output logic                mult_stall,
  output logic                mult_zero,
  output logic                mult_overflow,
  output logic                q_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                push_valid_s;
  mwb_entry_t          m4_entry_s;
  mwb_entry_t          head_entry_s;
  mwb_entry_t          retire_entry_s;
  logic [PTR_W-1:0]    head_ptr_s;
  logic [CNT_W-1:0]    count_s;
  logic                full_s;
  logic                empty_s;
  logic [REG_ADDR-1:0] entry_wreg_s [DEPTH];
  logic [REG_SIZE-1:0] entry_data_s [DEPTH];
  logic [DEPTH-1:0]    entry_valid_s;
  grant_e              grant_s;
  logic                pop_s;
  logic                fifo_push_s;
  logic                drop_s;
  logic                retire_s;
  logic [REG_ADDR-1:0] look_addr_s [2];
  logic                fwd_hit_s   [2];
  logic [REG_SIZE-1:0] fwd_data_s  [2];

  logic                rf_we_r;
  logic [REG_ADDR-1:0] rf_waddr_r;
  logic [REG_SIZE-1:0] rf_wdata_r;
  logic                mult_zero_r;
  logic                mult_overflow_r;
  logic                q_err_r;

  // Writes to r0 are architecturally void, so they never occupy the queue.
  assign push_valid_s = m_regwrite_in && (m_wreg_in != {REG_ADDR{1'b0}});
  assign m4_entry_s   = '{wreg: m_wreg_in, data: m_result_in, zero: m_zero_in, ovf: m_overflow_in};

  mult_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push_s),
    .pop         (pop_s),
    .push_entry  (m4_entry_s),
    .head_entry  (head_entry_s),
    .head_ptr    (head_ptr_s),
    .count       (count_s),
    .full        (full_s),
    .empty       (empty_s),
    .entry_wreg  (entry_wreg_s),
    .entry_data  (entry_data_s),
    .entry_valid (entry_valid_s)
  );

  // Port grant priority: main pipe, oldest queued result, then bypass of the live M4 result.
  always_comb begin
    grant_s = GRANT_IDLE;
    if (wb_regwrite) begin
      grant_s = GRANT_MAIN;
    end else if (!empty_s) begin
      grant_s = GRANT_POP;
    end else if (push_valid_s) begin
      grant_s = GRANT_BYPASS;
    end else begin
      grant_s = GRANT_IDLE;
    end
  end

  assign pop_s       = (grant_s == GRANT_POP);
  assign fifo_push_s = push_valid_s && (grant_s != GRANT_BYPASS) && (!full_s || pop_s);
  assign drop_s      = push_valid_s && full_s && !pop_s;
  assign retire_s    = (grant_s == GRANT_POP) || (grant_s == GRANT_BYPASS);

  // Select the entry whose flags get retired this cycle.
  always_comb begin
    retire_entry_s = ENTRY_ZERO;
    case (grant_s)
      GRANT_POP:    retire_entry_s = head_entry_s;
      GRANT_BYPASS: retire_entry_s = m4_entry_s;
      default:      retire_entry_s = ENTRY_ZERO;
    endcase
  end

  // Registered write port and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r         <= 1'b0;
      rf_waddr_r      <= {REG_ADDR{1'b0}};
      rf_wdata_r      <= {REG_SIZE{1'b0}};
      mult_zero_r     <= 1'b0;
      mult_overflow_r <= 1'b0;
      q_err_r         <= 1'b0;
    end else begin
      case (grant_s)
        GRANT_MAIN: begin
          rf_we_r    <= 1'b1;
          rf_waddr_r <= wb_wreg;
          rf_wdata_r <= wb_wdata;
        end
        GRANT_POP, GRANT_BYPASS: begin
          rf_we_r    <= 1'b1;
          rf_waddr_r <= retire_entry_s.wreg;
          rf_wdata_r <= retire_entry_s.data;
        end
        default: begin
          rf_we_r    <= 1'b0;
          rf_waddr_r <= {REG_ADDR{1'b0}};
          rf_wdata_r <= {REG_SIZE{1'b0}};
        end
      endcase
      if (retire_s) begin
        mult_zero_r     <= retire_entry_s.zero;
        mult_overflow_r <= mult_overflow_r | retire_entry_s.ovf;
      end
      if (drop_s) q_err_r <= 1'b1;
    end
  end

  assign look_addr_s[0] = rs_addr;
  assign look_addr_s[1] = rt_addr;

  // Walk oldest to youngest so the last match wins; the live M4 result is youngest of all.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit_s[p]  = 1'b0;
      fwd_data_s[p] = {REG_SIZE{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        fwd_hit_s[p]  = fwd_hit_s[p] |
                        (entry_valid_s[head_ptr_s + PTR_W'(k)] &&
                         (entry_wreg_s[head_ptr_s + PTR_W'(k)] == look_addr_s[p]));
        fwd_data_s[p] = (entry_valid_s[head_ptr_s + PTR_W'(k)] &&
                         (entry_wreg_s[head_ptr_s + PTR_W'(k)] == look_addr_s[p]))
                        ? entry_data_s[head_ptr_s + PTR_W'(k)] : fwd_data_s[p];
      end
      fwd_hit_s[p]  = fwd_hit_s[p] | (push_valid_s && (m_wreg_in == look_addr_s[p]));
      fwd_data_s[p] = (push_valid_s && (m_wreg_in == look_addr_s[p])) ? m_result_in : fwd_data_s[p];
      fwd_hit_s[p]  = fwd_hit_s[p] && (look_addr_s[p] != {REG_ADDR{1'b0}});
    end
  end

  assign fwd_rs_hit  = fwd_hit_s[0];
  assign fwd_rs_data = fwd_data_s[0];
  assign fwd_rt_hit  = fwd_hit_s[1];
  assign fwd_rt_data = fwd_data_s[1];

  // Leaves room for every op already between M1 and M4 to land without overflow.
  assign mult_stall = (count_s >= CNT_W'(DEPTH - MULT_LAT));

  assign rf_we         = rf_we_r;
  assign rf_waddr      = rf_waddr_r;
  assign rf_wdata      = rf_wdata_r;
  assign mult_zero     = mult_zero_r;
  assign mult_overflow = mult_overflow_r;
  assign q_err         = q_err_r;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Directed and randomized bench for mult_wb_arbiter against a queue-based reference model.
module tb_mult_wb_arbiter;
  import mult_wb_arbiter_pkg::*;

  localparam int DEPTH = MWB_DEPTH;
  localparam int LAT   = MWB_MULT_LAT;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_regwrite_in, m_zero_in, m_overflow_in;
  logic [4:0]  m_wreg_in, wb_wreg, rs_addr, rt_addr;
  logic [31:0] m_result_in, wb_wdata;
  logic        wb_regwrite;
  logic        rf_we, fwd_rs_hit, fwd_rt_hit, mult_stall, mult_zero, mult_overflow, q_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, fwd_rs_data, fwd_rt_data;

  mult_wb_arbiter #(.DEPTH(DEPTH), .MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .m_regwrite_in(m_regwrite_in), .m_wreg_in(m_wreg_in), .m_result_in(m_result_in),
    .m_zero_in(m_zero_in), .m_overflow_in(m_overflow_in),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data),
    .mult_stall(mult_stall), .mult_zero(mult_zero), .mult_overflow(mult_overflow),
    .q_err(q_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        z;
    logic        o;
  } ment_t;

  ment_t       mq[$];
  logic        e_we, e_z, e_o, e_qerr;
  logic [4:0]  e_a;
  logic [31:0] e_d;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_m4(input logic rw, input logic [4:0] a, input logic [31:0] d,
                        input logic z, input logic o);
    m_regwrite_in = rw; m_wreg_in = a; m_result_in = d; m_zero_in = z; m_overflow_in = o;
  endtask

  task automatic set_wb(input logic rw, input logic [4:0] a, input logic [31:0] d);
    wb_regwrite = rw; wb_wreg = a; wb_wdata = d;
  endtask

  // Youngest matching result wins; the live M4 value is younger than anything queued.
  task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = 32'h0;
    foreach (mq[i]) if (mq[i].a == a) begin hit = 1'b1; d = mq[i].d; end
    if (m_regwrite_in && m_wreg_in != 5'd0 && m_wreg_in == a) begin hit = 1'b1; d = m_result_in; end
    if (a == 5'd0) hit = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic        h, valid;
    logic [31:0] d;
    ment_t       e, m4;
    #1;
    model_fwd(rs_addr, h, d);
    check("fwd_rs_hit", fwd_rs_hit, h);
    if (h) check("fwd_rs_data", fwd_rs_data, d);
    model_fwd(rt_addr, h, d);
    check("fwd_rt_hit", fwd_rt_hit, h);
    if (h) check("fwd_rt_data", fwd_rt_data, d);
    check("mult_stall", mult_stall, mq.size() >= DEPTH - LAT);
    valid = m_regwrite_in && (m_wreg_in != 5'd0);
    m4 = '{a: m_wreg_in, d: m_result_in, z: m_zero_in, o: m_overflow_in};
    if (reset) begin
      mq.delete();
      e_we = 1'b0; e_a = 5'd0; e_d = 32'h0; e_z = 1'b0; e_o = 1'b0; e_qerr = 1'b0;
    end else if (wb_regwrite) begin
      e_we = 1'b1; e_a = wb_wreg; e_d = wb_wdata;
      if (valid) begin
        if (mq.size() < DEPTH) mq.push_back(m4);
        else e_qerr = 1'b1;
      end
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
      e_we = 1'b1; e_a = e.a; e_d = e.d; e_z = e.z; e_o = e_o | e.o;
      if (valid) mq.push_back(m4);
    end else if (valid) begin
      e_we = 1'b1; e_a = m4.a; e_d = m4.d; e_z = m4.z; e_o = e_o | m4.o;
    end else begin
      e_we = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_a);
      check("rf_wdata", rf_wdata, e_d);
    end
    check("mult_zero", mult_zero, e_z);
    check("mult_overflow", mult_overflow, e_o);
    check("q_err", q_err, e_qerr);
    check("count", dut.count_s, mq.size());
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'h0);
    rs_addr = 5'd0; rt_addr = 5'd0;
    e_we = 1'b0; e_a = 5'd0; e_d = 32'h0; e_z = 1'b0; e_o = 1'b0; e_qerr = 1'b0;
    @(negedge clk);
    step(); step();
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_q_err", q_err, 1'b0);
    reset = 1'b0;

    // Bypass with an idle main pipe
    set_m4(1'b1, 5'd5, 32'h12345678, 1'b0, 1'b0);
    step();
    check("t1_we", rf_we, 1'b1);
    check("t1_addr", rf_waddr, 5'd5);
    check("t1_data", rf_wdata, 32'h12345678);
    check("t1_count", dut.count_s, 0);

    // Main pipe blocks three cycles, queued results drain in order after
    rs_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      set_wb(1'b1, 5'd20 + 5'(i), 32'h100 + 32'(i));
      set_m4(1'b1, 5'd1 + 5'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
      step();
      check("t2_main_data", rf_wdata, 32'h100 + 32'(i));
    end
    set_wb(1'b0, 5'd0, 32'h0);
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_order", rf_waddr, 5'd1 + 5'(i));
    end

    // Youngest-match forwarding
    set_wb(1'b1, 5'd9, 32'h9);
    set_m4(1'b1, 5'd7, 32'hA, 1'b0, 1'b0); step();
    set_m4(1'b1, 5'd7, 32'hB, 1'b0, 1'b0); step();
    rs_addr = 5'd7;
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 check("t3_fwd_B", fwd_rs_data, 32'hB);
    set_m4(1'b1, 5'd7, 32'hC, 1'b0, 1'b0);
    #1 check("t3_fwd_C", fwd_rs_data, 32'hC);
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (4) step();

    // Fill to full, then overflow
    set_wb(1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 4; i++) begin
      set_m4(1'b1, 5'd10 + 5'(i), 32'h200 + 32'(i), 1'b0, 1'b1);
      step();
    end
    check("t4_stall", mult_stall, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_m4(1'b1, 5'd14 + 5'(i), 32'h300 + 32'(i), 1'b1, 1'b0);
      step();
    end
    check("t4_count", dut.count_s, 8);
    check("t4_qerr", q_err, 1'b1);
    set_wb(1'b0, 5'd0, 32'h0);
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    repeat (9) step();

    // Write to r0 is dropped
    set_m4(1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1);
    step();
    check("t5_no_write", rf_we, 1'b0);
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // Reset with three entries queued
    set_wb(1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      set_m4(1'b1, 5'd21 + 5'(i), 32'h400 + 32'(i), 1'b1, 1'b1);
      step();
    end
    set_wb(1'b0, 5'd0, 32'h0);
    set_m4(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check("t6_we", rf_we, 1'b0);
    check("t6_count", dut.count_s, 0);
    check("t6_ovf", mult_overflow, 1'b0);
    check("t6_qerr", q_err, 1'b0);
    reset = 1'b0;
    step();
    check("t6_no_stale", rf_we, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      r = $urandom;
      set_wb(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom);
      set_m4(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
             r[0], ($urandom_range(0, 15) == 0));
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
